alu_issue_stage: RTL and testbench

- ID/EX issue stage that produces everything the EX-stage ALU consumes: 4-bit ALU control, operand A, operand B and store data.
- Decodes the main-control ALUOp plus the 11-bit LEGv8 opcode into the ALU control code.
- Registers the decoded code and the operands into the ID/EX register, with stall and flush.
- Applies EX/MEM and MEM/WB forwarding on the registered operands, so the ALU always sees the newest values.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 48 ++++
 rtl/alu_issue_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ID/EX issue stage: ALU control codes, main-control
// ALUOp encodings, the LEGv8 R-type opcodes the ALU decoder recognises, and
// the zero-register index.
// ---------------------------------------------------------------------------
package alu_pkg;

  // 4-bit ALU control codes consumed by the EX-stage ALU
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // Main-control ALUOp encodings (2'b11 is unused and treated as illegal)
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // instruction[31:21] of the supported R-type operations
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  // X31 reads as zero and is never a forwarding source
  localparam int unsigned XZR = 31;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALU-control decoder. Maps the main-control ALUOp and
// the 11-bit opcode onto the 4-bit ALU control code and flags pairs that the
// ALU cannot execute.
//
// Ports:
//   alu_op      in  2   main-control ALUOp
//   opcode      in  11  instruction[31:21]
//   alu_control out 4   ALU control code
//   illegal     out 1   ALUOp/opcode pair has no ALU meaning
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  alu_control,
  output logic        illegal
);

  always_comb begin
    // Undecodable cases fall through to pass-b with the illegal flag raised
    alu_control = ALU_PASSB;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_control = ALU_ADD;
      ALUOP_CBZ: alu_control = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (opcode)
          OP_ADD:  alu_control = ALU_ADD;
          OP_SUB:  alu_control = ALU_SUB;
          OP_AND:  alu_control = ALU_AND;
          OP_ORR:  alu_control = ALU_ORR;
          default: begin
            alu_control = ALU_PASSB;
            illegal     = 1'b1;
          end
        endcase
      end
      default: begin
        alu_control = ALU_PASSB;
        illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX issue stage. Decodes the ALU control code in ID, captures it together
// with the operands in the ID/EX register (stall holds, flush inserts a
// bubble), and forwards EX/MEM and MEM/WB results onto the registered
// operands so the ALU always sees the newest register values.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_alu_op, id_opcode        decoder inputs
//   id_alu_src                  1 = operand B is the immediate
//   id_rd1, id_rd2, id_imm      register-file reads and immediate
//   id_rn, id_rm                source register indices
//   stall, flush                ID/EX hold / bubble
//   exmem_reg_write/rd/result   EX/MEM forwarding source
//   memwb_reg_write/rd/data     MEM/WB forwarding source
//   ex_valid, ex_alu_control    registered control to EX
//   ex_a, ex_b, ex_store_data   forwarded operands to EX
//   ex_illegal                  registered undecodable flag
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_op,
  input  logic [10:0]   id_opcode,
  input  logic          id_alu_src,
  input  logic [N-1:0]  id_rd1,
  input  logic [N-1:0]  id_rd2,
  input  logic [N-1:0]  id_imm,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [N-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [N-1:0]  memwb_data,
  output logic          ex_valid,
  output logic [3:0]    ex_alu_control,
  output logic [N-1:0]  ex_a,
  output logic [N-1:0]  ex_b,
  output logic [N-1:0]  ex_store_data,
  output logic          ex_illegal
);

  localparam logic [RW-1:0] XZR_IDX = RW'(XZR);

  // EX/MEM wins over MEM/WB; the zero register is never forwarded
  function automatic logic [N-1:0] fwd_operand(
    input logic [RW-1:0] idx,
    input logic [N-1:0]  reg_val,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [N-1:0]  em_val,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [N-1:0]  mw_val
  );
    logic [N-1:0] res;
    res = reg_val;
    if (idx != XZR_IDX) begin
      if (em_we && (em_rd == idx))      res = em_val;
      else if (mw_we && (mw_rd == idx)) res = mw_val;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- ID stage
  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .alu_op      (id_alu_op),
    .opcode      (id_opcode),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  logic          valid_q,   valid_d;
  logic [3:0]    ctrl_q,    ctrl_d;
  logic          illegal_q, illegal_d;
  logic          src_q,     src_d;
  logic [N-1:0]  rd1_q,     rd1_d;
  logic [N-1:0]  rd2_q,     rd2_d;
  logic [N-1:0]  imm_q,     imm_d;
  logic [RW-1:0] rn_q,      rn_d;
  logic [RW-1:0] rm_q,      rm_d;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    src_d     = src_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    imm_d     = imm_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    if (flush) begin
      // Bubble; flush beats a simultaneous stall
      valid_d   = 1'b0;
      ctrl_d    = ALU_PASSB;
      illegal_d = 1'b0;
      src_d     = 1'b0;
      rd1_d     = '0;
      rd2_d     = '0;
      imm_d     = '0;
      rn_d      = '0;
      rm_d      = '0;
    end else if (!stall) begin
      // Loads even for a non-valid ID slot; only illegal is gated by valid
      valid_d   = id_valid;
      ctrl_d    = dec_ctrl;
      illegal_d = id_valid & dec_illegal;
      src_d     = id_alu_src;
      rd1_d     = id_rd1;
      rd2_d     = id_rd2;
      imm_d     = id_imm;
      rn_d      = id_rn;
      rm_d      = id_rm;
    end
  end

  // ------------------------------------------------------- ID/EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= ALU_PASSB;
      illegal_q <= 1'b0;
      src_q     <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      src_q     <= src_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
    end
  end

  // ---------------------------------------------------------------- EX stage
  // Forwarding is re-evaluated every cycle, so a stalled instruction keeps
  // tracking newer EX/MEM and MEM/WB values.
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  assign fwd_a = fwd_operand(rn_q, rd1_q, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_data);
  assign fwd_b = fwd_operand(rm_q, rd2_q, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_data);

  assign ex_valid       = valid_q;
  assign ex_alu_control = ctrl_q;
  assign ex_illegal     = illegal_q;
  assign ex_a           = fwd_a;
  assign ex_b           = src_q ? imm_q : fwd_b;
  // Store data is Rt regardless of the immediate select
  assign ex_store_data  = fwd_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [1:0]  id_alu_op = 2'b11;
  logic [10:0] id_opcode = '0;
  logic        id_alu_src = 1'b0;
  logic [63:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rn = '0, id_rm = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        exmem_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic [63:0] exmem_result = '0;
  logic        memwb_reg_write = 1'b0;
  logic [4:0]  memwb_rd = '0;
  logic [63:0] memwb_data = '0;
  logic        ex_valid;
  logic [3:0]  ex_alu_control;
  logic [63:0] ex_a, ex_b, ex_store_data;
  logic        ex_illegal;

  alu_issue_stage #(.N(64), .RW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_opcode(id_opcode), .id_alu_src(id_alu_src), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rn(id_rn), .id_rm(id_rm),
    .stall(stall), .flush(flush), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .ex_valid(ex_valid),
    .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently held for EX
  typedef struct {
    bit          valid;
    bit [3:0]    ctrl;
    bit          ill;
    bit          imm_sel;
    bit [63:0]   a_reg, b_reg, imm;
    int unsigned a_src, b_src;
  } instr_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic        ill;
    logic [63:0] a, b, sd;
  } exp_t;

  instr_t held;
  bit     known = 0;
  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic instr_t bubble();
    instr_t t;
    t.valid = 0; t.ctrl = 4'd7; t.ill = 0; t.imm_sel = 0;
    t.a_reg = 0; t.b_reg = 0; t.imm = 0; t.a_src = 0; t.b_src = 0;
    return t;
  endfunction

  // ALU control from the instruction mnemonic table; {ctrl, illegal}
  function automatic bit [4:0] ref_decode(bit [1:0] op, bit [10:0] opc);
    if (op == 2'd0) return {4'd2, 1'b0};
    if (op == 2'd1) return {4'd7, 1'b0};
    if (op == 2'd2) begin
      if (opc == 11'h458) return {4'd2, 1'b0};  // ADD
      if (opc == 11'h658) return {4'd6, 1'b0};  // SUB
      if (opc == 11'h450) return {4'd0, 1'b0};  // AND
      if (opc == 11'h550) return {4'd1, 1'b0};  // ORR
    end
    return {4'd7, 1'b1};
  endfunction

  // Newest value of register idx, given the register-file copy
  function automatic bit [63:0] newest(int unsigned idx, bit [63:0] rf_val);
    if (idx == 31) return rf_val;
    if (exmem_reg_write && int'(exmem_rd) == idx) return exmem_result;
    if (memwb_reg_write && int'(memwb_rd) == idx) return memwb_data;
    return rf_val;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.v   = held.valid;
    e.c   = held.ctrl;
    e.ill = held.ill;
    e.a   = newest(held.a_src, held.a_reg);
    e.sd  = newest(held.b_src, held.b_reg);
    e.b   = held.imm_sel ? held.imm : e.sd;
    return e;
  endfunction

  task automatic model_edge();
    bit [4:0] d;
    if (reset) begin
      held = bubble(); known = 1;
    end else if (flush) begin
      held = bubble();
    end else if (!stall) begin
      d = ref_decode(id_alu_op, id_opcode);
      held.valid = id_valid; held.ctrl = d[4:1]; held.ill = d[0] & id_valid;
      held.imm_sel = id_alu_src; held.a_reg = id_rd1; held.b_reg = id_rd2;
      held.imm = id_imm; held.a_src = id_rn; held.b_src = id_rm;
    end
  endtask

  // Publishes the expectation for the current (pre-edge) cycle, then advances
  task automatic tick();
    if (known) sb.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(bit v, bit [1:0] op, bit [10:0] opc, bit src,
                        bit [63:0] r1, bit [63:0] r2, bit [63:0] im,
                        bit [4:0] rn, bit [4:0] rm);
    id_valid = v; id_alu_op = op; id_opcode = opc; id_alu_src = src;
    id_rd1 = r1; id_rd2 = r2; id_imm = im; id_rn = rn; id_rm = rm;
  endtask

  task automatic set_fwd(bit ew, bit [4:0] erd, bit [63:0] ev,
                         bit mw, bit [4:0] mrd, bit [63:0] mv);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = ev;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_data = mv;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ex_valid",       64'(ex_valid),       64'(e.v));
        chk("ex_alu_control", 64'(ex_alu_control), 64'(e.c));
        chk("ex_illegal",     64'(ex_illegal),     64'(e.ill));
        chk("ex_a",           ex_a,                e.a);
        chk("ex_b",           ex_b,                e.b);
        chk("ex_store_data",  ex_store_data,       e.sd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam bit [10:0] OPC_ADD = 11'b10001011000;
  localparam bit [10:0] OPC_SUB = 11'b11001011000;
  localparam bit [10:0] OPC_AND = 11'b10001010000;
  localparam bit [10:0] OPC_ORR = 11'b10101010000;
  localparam bit [10:0] OPC_LDUR = 11'b11111000010;

  initial begin
    bit [10:0] opc_tab[5];
    int unsigned k;
    held = bubble();
    opc_tab[0] = OPC_ADD; opc_tab[1] = OPC_SUB; opc_tab[2] = OPC_AND;
    opc_tab[3] = OPC_ORR; opc_tab[4] = OPC_LDUR;

    // Reset two cycles, release with an idle ID slot
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // Decode sweep
    set_id(1, 2'b10, OPC_ADD, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b10, OPC_SUB, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b10, OPC_AND, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b10, OPC_ORR, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b00, OPC_LDUR, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b01, OPC_LDUR, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b10, OPC_LDUR, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(1, 2'b11, OPC_ADD, 0, 64'h11, 64'h22, 0, 1, 2); tick();
    set_id(0, 2'b10, OPC_LDUR, 0, 64'h11, 64'h22, 0, 1, 2); tick();

    // Immediate select
    set_id(1, 2'b00, 0, 1, 64'h5, 64'h99, 64'h10, 4, 9); tick();

    // Forwarding priority and the zero register
    set_id(1, 2'b10, OPC_ADD, 0, 64'h1, 64'h1, 0, 3, 3);
    set_fwd(1, 3, 64'hAA, 1, 3, 64'hBB); tick();
    tick();
    set_fwd(0, 3, 64'hAA, 1, 3, 64'hBB); tick();
    set_fwd(1, 3, 64'hAA, 0, 3, 64'hBB); tick();
    set_id(1, 2'b10, OPC_ADD, 0, 64'h1, 64'h2, 0, 31, 31);
    set_fwd(1, 31, 64'hAA, 1, 31, 64'hBB); tick();
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Stall with changing ID and EX/MEM inputs
    set_id(1, 2'b10, OPC_SUB, 0, 64'h100, 64'h200, 0, 6, 7); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 2'b10, OPC_ORR, 1, 64'h300 + i, 64'h400, 64'h7, 8, 9);
      set_fwd(1, 6, 64'hC0DE0000 + 64'(i), 0, 0, 0);
      tick();
    end
    set_fwd(1, 6, 64'hFEED, 1, 7, 64'hBEEF);
    tick();
    stall = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // Flush beats stall
    set_id(1, 2'b10, OPC_ADD, 0, 64'h12, 64'h34, 0, 1, 2); tick();
    flush = 1'b1; stall = 1'b1; tick();
    flush = 1'b0; stall = 1'b0; tick();
    // Reset mid-stream
    reset = 1'b1; tick();
    reset = 1'b0; set_id(1, 2'b10, OPC_AND, 0, 64'h55, 64'h66, 0, 5, 5); tick();
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(99) == 0);
      flush = ($urandom_range(11) == 0);
      stall = ($urandom_range(5) == 0);
      k = $urandom_range(4);
      set_id($urandom_range(1), 2'($urandom_range(3)), opc_tab[k],
             $urandom_range(1), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(3)),
             ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(3)));
      set_fwd($urandom_range(1), ($urandom_range(4) == 0) ? 5'd31 : 5'($urandom_range(3)),
              {$urandom, $urandom},
              $urandom_range(1), ($urandom_range(4) == 0) ? 5'd31 : 5'($urandom_range(3)),
              {$urandom, $urandom});
      tick();
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    tick();

    // Drain: the last expectation is consumed at the next falling edge
    sb.push_back(predict());
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
